// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive-path controller: oversampling tick, receive FIFO, status and irq
//
// Purpose:
//   Produces the 16x-oversampling tick for the UART receiver. Collects received
//   bytes into a small FIFO and hands them to the register block one per read
//   request. Also keeps sticky overrun/frame-error flags and drives a level
//   interrupt.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   en                receive enable; gates the tick generator and FIFO pushes
//   clk_div           tick period minus one, in clk cycles
//   flush             single-cycle pulse that empties the FIFO
//   err_clr           clears the sticky overrun/frame_error flags
//   irq_threshold     level interrupt threshold (0 disables the level term)
//   sck_rising_edge   registered oversampling tick to the receiver
//   rx_busy           receiver busy; its rising edge realigns the tick phase
//   rx_data_valid     receiver byte-complete pulse
//   rx_data, rx_error received byte and its stop-bit error flag
//   rd_req            pop request from the register block
//   rd_data, rd_valid popped byte and its one-cycle valid pulse
//   level             number of entries held
//   rx_not_empty      level != 0
//   rx_full           level == FIFO_DEPTH
//   overrun           sticky: a byte was dropped because the FIFO was full
//   frame_error       sticky: a byte arrived with rx_error set
//   irq               interrupt
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic [DIV_WIDTH-1:0]              clk_div,
  input  logic                              flush,
  input  logic                              err_clr,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0]   irq_threshold,
  output logic                              sck_rising_edge,
  input  logic                              rx_busy,
  input  logic                              rx_data_valid,
  input  logic [7:0]                        rx_data,
  input  logic                              rx_error,
  input  logic                              rd_req,
  output logic [7:0]                        rd_data,
  output logic                              rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              rx_not_empty,
  output logic                              rx_full,
  output logic                              overrun,
  output logic                              frame_error,
  output logic                              irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Tick generator
  // ---------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] cnt;
  logic                 busy_q;
  logic                 busy_rise;

  // A new frame starting restarts the oversampling phase so the receiver
  // samples relative to the start-bit edge rather than a free-running count.
  assign busy_rise = rx_busy & ~busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      busy_q          <= 1'b0;
      sck_rising_edge <= 1'b0;
    end else begin
      busy_q <= rx_busy;
      if (!en) begin
        cnt             <= '0;
        sck_rising_edge <= 1'b0;
      end else if (busy_rise) begin
        // Realign wins over a tick that would have landed on this cycle.
        cnt             <= '0;
        sck_rising_edge <= 1'b0;
      end else if (cnt >= clk_div) begin
        // >= rather than == so a divider lowered below the current count
        // ticks immediately instead of wrapping the whole counter range.
        cnt             <= '0;
        sck_rising_edge <= 1'b1;
      end else begin
        cnt             <= cnt + DIV_WIDTH'(1);
        sck_rising_edge <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] lvl;

  logic is_full;
  logic is_empty;
  logic push_req;
  logic push_ok;
  logic pop;
  logic drop;
  logic ferr_set;

  assign is_full  = (lvl == LW'(FIFO_DEPTH));
  assign is_empty = (lvl == '0);

  // Flush discards both sides of the FIFO traffic in its cycle.
  assign push_req = en & rx_data_valid & ~flush;
  assign pop      = rd_req & ~is_empty & ~flush;

  // A pop in the same cycle frees the slot the push needs, so a full FIFO
  // with a concurrent read still accepts the byte.
  assign push_ok  = push_req & (~is_full | pop);
  assign drop     = push_req & is_full & ~pop;
  assign ferr_set = push_req & rx_error;

  // Storage carries no reset; entries are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lvl      <= '0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lvl      <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        // At full with a concurrent push, wr_ptr == rd_ptr; the read still
        // returns the old entry because the write lands at the clock edge.
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   lvl <= lvl + LW'(1);
        2'b01:   lvl <= lvl - LW'(1);
        default: lvl <= lvl;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a set in the same cycle as err_clr takes precedence.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      overrun     <= drop     | (overrun     & ~err_clr);
      frame_error <= ferr_set | (frame_error & ~err_clr);
    end
  end

  // ---------------------------------------------------------------------------
  // Status and interrupt, all derived from registers
  // ---------------------------------------------------------------------------
  assign level        = lvl;
  assign rx_not_empty = ~is_empty;
  assign rx_full      = is_full;
  assign irq          = ((irq_threshold != '0) && (lvl >= irq_threshold))
                        | overrun | frame_error;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] clk_div;
  logic        flush;
  logic        err_clr;
  logic [2:0]  irq_threshold;
  logic        sck_rising_edge;
  logic        rx_busy;
  logic        rx_data_valid;
  logic [7:0]  rx_data;
  logic        rx_error;
  logic        rd_req;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [2:0]  level;
  logic        rx_not_empty;
  logic        rx_full;
  logic        overrun;
  logic        frame_error;
  logic        irq;

  int checks = 0;
  int errors = 0;

  uart_rx_ctrl #(.FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clk_div(clk_div), .flush(flush),
    .err_clr(err_clr), .irq_threshold(irq_threshold),
    .sck_rising_edge(sck_rising_edge), .rx_busy(rx_busy),
    .rx_data_valid(rx_data_valid), .rx_data(rx_data), .rx_error(rx_error),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
    .rx_not_empty(rx_not_empty), .rx_full(rx_full), .overrun(overrun),
    .frame_error(frame_error), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       vld;
    logic [7:0] d;
    logic       err;
    logic       rd;
    logic       fl;
    logic       clr;
    logic [2:0] thr;
    logic [2:0] lvl;
    logic       rv;
    logic [7:0] rdd;
    logic       ov;
    logic       fe;
    logic       irq;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic e, input logic v, input logic [7:0] d,
                              input logic er, input logic r, input logic f,
                              input logic c, input logic [2:0] t,
                              input logic [2:0] l, input logic rv,
                              input logic [7:0] rdd, input logic ov,
                              input logic fe, input logic iq);
    vec_t x;
    x.en = e; x.vld = v; x.d = d; x.err = er; x.rd = r; x.fl = f; x.clr = c;
    x.thr = t; x.lvl = l; x.rv = rv; x.rdd = rdd; x.ov = ov; x.fe = fe;
    x.irq = iq;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rx_data_valid = 1'b0;
    rx_data       = 8'h00;
    rx_error      = 1'b0;
    rd_req        = 1'b0;
    flush         = 1'b0;
    err_clr       = 1'b0;
  endtask

  logic [15:0] mask;
  int          first_tick;
  string       nm;

  initial begin
    rst_n = 1'b0; en = 1'b0; clk_div = 16'd3; irq_threshold = 3'd0;
    rx_busy = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sck", sck_rising_edge, 1'b0);
    chk("rst_level", level, 3'd0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_frame_error", frame_error, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_not_empty", rx_not_empty, 1'b0);
    chk("rst_full", rx_full, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick_edge();

    // en=0: no ticks at all
    mask = '0;
    for (int k = 0; k < 8; k++) begin tick_edge(); mask[k] = sck_rising_edge; end
    chk("tick_en0", mask, 16'h0000);

    // clk_div=3: one tick every 4 clocks, first on the 4th edge
    clk_div = 16'd3; en = 1'b1;
    for (int k = 0; k < 16; k++) begin tick_edge(); mask[k] = sck_rising_edge; end
    chk("tick_div3", mask, 16'h8888);

    // clk_div=0: tick every clock
    clk_div = 16'd0;
    mask = '0;
    for (int k = 0; k < 8; k++) begin tick_edge(); mask[k] = sck_rising_edge; end
    chk("tick_div0", mask, 16'h00FF);

    // en=0 holds the counter at 0: re-enable with div 3 ticks on the 4th edge
    en = 1'b0;
    mask = '0;
    for (int k = 0; k < 3; k++) begin tick_edge(); mask[k] = sck_rising_edge; end
    chk("tick_en0_again", mask, 16'h0000);
    clk_div = 16'd3; en = 1'b1;
    mask = '0;
    for (int k = 0; k < 4; k++) begin tick_edge(); mask[k] = sck_rising_edge; end
    chk("tick_restart", mask, 16'h0008);

    // divider lowered below the current count ticks on the next cycle
    en = 1'b0; tick_edge();
    en = 1'b1; clk_div = 16'd15;
    for (int k = 0; k < 8; k++) tick_edge();
    clk_div = 16'd2;
    tick_edge();
    chk("tick_div_decrease", sck_rising_edge, 1'b1);

    // realign: rise with counter=9, next tick exactly 16 clocks later
    en = 1'b0; clk_div = 16'd15; tick_edge();
    en = 1'b1;
    mask = '0;
    for (int k = 0; k < 9; k++) begin tick_edge(); mask[k] = sck_rising_edge; end
    chk("realign_pre", mask, 16'h0000);
    rx_busy = 1'b1;
    tick_edge();
    chk("realign_rise_cycle", sck_rising_edge, 1'b0);
    first_tick = -1;
    for (int k = 1; k <= 20; k++) begin
      tick_edge();
      if (sck_rising_edge && first_tick < 0) first_tick = k;
    end
    chk("realign_period", first_tick, 32'd16);

    // realign on the boundary cycle suppresses the tick
    rx_busy = 1'b0; en = 1'b0; tick_edge();
    en = 1'b1;
    for (int k = 0; k < 15; k++) tick_edge();
    rx_busy = 1'b1;
    tick_edge();
    chk("realign_boundary_suppressed", sck_rising_edge, 1'b0);
    first_tick = -1;
    for (int k = 1; k <= 20; k++) begin
      tick_edge();
      if (sck_rising_edge && first_tick < 0) first_tick = k;
    end
    chk("realign_boundary_period", first_tick, 32'd16);
    rx_busy = 1'b0;

    // FIFO vectors:        en vld  d    err rd fl clr thr  lvl rv rdd   ov fe irq
    vq.push_back(mk(1,1,8'hA5,0,0,0,0,3'd0, 3'd1,0,8'h00,0,0,0));
    vq.push_back(mk(1,1,8'h3C,0,0,0,0,3'd0, 3'd2,0,8'h00,0,0,0));
    vq.push_back(mk(1,1,8'h01,0,0,0,0,3'd0, 3'd3,0,8'h00,0,0,0));
    vq.push_back(mk(1,0,8'h00,0,1,0,0,3'd0, 3'd2,1,8'hA5,0,0,0));
    vq.push_back(mk(1,0,8'h00,0,1,0,0,3'd0, 3'd1,1,8'h3C,0,0,0));
    vq.push_back(mk(1,0,8'h00,0,1,0,0,3'd0, 3'd0,1,8'h01,0,0,0));
    vq.push_back(mk(1,0,8'h00,0,1,0,0,3'd0, 3'd0,0,8'h01,0,0,0));
    vq.push_back(mk(1,1,8'h10,0,0,0,0,3'd0, 3'd1,0,8'h01,0,0,0));
    vq.push_back(mk(1,1,8'h11,0,0,0,0,3'd0, 3'd2,0,8'h01,0,0,0));
    vq.push_back(mk(1,1,8'h12,0,0,0,0,3'd0, 3'd3,0,8'h01,0,0,0));
    vq.push_back(mk(1,1,8'h13,0,0,0,0,3'd0, 3'd4,0,8'h01,0,0,0));
    vq.push_back(mk(1,1,8'h14,0,0,0,0,3'd0, 3'd4,0,8'h01,1,0,1));
    vq.push_back(mk(1,0,8'h00,0,0,0,1,3'd0, 3'd4,0,8'h01,0,0,0));
    vq.push_back(mk(1,1,8'h20,0,1,0,0,3'd0, 3'd4,1,8'h10,0,0,0));
    vq.push_back(mk(1,0,8'h00,0,1,0,0,3'd0, 3'd3,1,8'h11,0,0,0));
    vq.push_back(mk(1,0,8'h00,0,1,0,0,3'd0, 3'd2,1,8'h12,0,0,0));
    vq.push_back(mk(1,0,8'h00,0,1,0,0,3'd0, 3'd1,1,8'h13,0,0,0));
    vq.push_back(mk(1,0,8'h00,0,1,0,0,3'd0, 3'd0,1,8'h20,0,0,0));
    vq.push_back(mk(1,1,8'h55,1,0,0,0,3'd0, 3'd1,0,8'h20,0,1,1));
    vq.push_back(mk(1,0,8'h00,0,1,0,0,3'd0, 3'd0,1,8'h55,0,1,1));
    vq.push_back(mk(1,1,8'h66,1,0,0,1,3'd0, 3'd1,0,8'h55,0,1,1));
    vq.push_back(mk(1,0,8'h00,0,0,0,1,3'd0, 3'd1,0,8'h55,0,0,0));
    vq.push_back(mk(1,0,8'h00,0,1,0,0,3'd0, 3'd0,1,8'h66,0,0,0));
    vq.push_back(mk(1,1,8'h77,0,0,0,0,3'd2, 3'd1,0,8'h66,0,0,0));
    vq.push_back(mk(1,1,8'h78,0,0,0,0,3'd2, 3'd2,0,8'h66,0,0,1));
    vq.push_back(mk(1,1,8'h79,0,0,0,0,3'd2, 3'd3,0,8'h66,0,0,1));
    vq.push_back(mk(1,1,8'h7A,0,0,0,0,3'd2, 3'd4,0,8'h66,0,0,1));
    vq.push_back(mk(1,1,8'h7B,0,0,0,0,3'd2, 3'd4,0,8'h66,1,0,1));
    vq.push_back(mk(1,1,8'h7C,0,1,1,0,3'd2, 3'd0,0,8'h66,1,0,1));
    vq.push_back(mk(1,0,8'h00,0,0,0,1,3'd2, 3'd0,0,8'h66,0,0,0));
    vq.push_back(mk(0,1,8'hEE,1,0,0,0,3'd2, 3'd0,0,8'h66,0,0,0));
    vq.push_back(mk(1,1,8'h90,0,0,0,0,3'd2, 3'd1,0,8'h66,0,0,0));
    vq.push_back(mk(0,0,8'h00,0,1,0,0,3'd2, 3'd0,1,8'h90,0,0,0));
    vq.push_back(mk(1,1,8'h91,0,0,0,0,3'd2, 3'd1,0,8'h90,0,0,0));
    vq.push_back(mk(1,0,8'h00,0,1,0,0,3'd2, 3'd0,1,8'h91,0,0,0));

    clk_div = 16'd3;
    foreach (vq[i]) begin
      en = vq[i].en; rx_data_valid = vq[i].vld; rx_data = vq[i].d;
      rx_error = vq[i].err; rd_req = vq[i].rd; flush = vq[i].fl;
      err_clr = vq[i].clr; irq_threshold = vq[i].thr;
      tick_edge();
      nm = $sformatf("v%0d_", i);
      chk({nm, "level"}, level, vq[i].lvl);
      chk({nm, "rd_valid"}, rd_valid, vq[i].rv);
      chk({nm, "rd_data"}, rd_data, vq[i].rdd);
      chk({nm, "overrun"}, overrun, vq[i].ov);
      chk({nm, "frame_error"}, frame_error, vq[i].fe);
      chk({nm, "irq"}, irq, vq[i].irq);
      chk({nm, "not_empty"}, rx_not_empty, vq[i].lvl != 3'd0);
      chk({nm, "full"}, rx_full, vq[i].lvl == 3'd4);
    end
    idle_inputs();
    en = 1'b1;

    // asynchronous reset mid-stream
    clk_div = 16'd0; rx_busy = 1'b1;
    rx_data_valid = 1'b1; rx_data = 8'hC3; rx_error = 1'b1;
    tick_edge();
    rx_data = 8'h4D; rx_error = 1'b0;
    tick_edge();
    rx_data_valid = 1'b0; rd_req = 1'b1;
    tick_edge();
    rd_req = 1'b0;
    chk("pre_rst_rd_data", rd_data, 8'hC3);
    chk("pre_rst_level", level, 3'd1);
    chk("pre_rst_sck", sck_rising_edge, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sck", sck_rising_edge, 1'b0);
    chk("async_rst_level", level, 3'd0);
    chk("async_rst_rd_data", rd_data, 8'h00);
    chk("async_rst_rd_valid", rd_valid, 1'b0);
    chk("async_rst_frame_error", frame_error, 1'b0);
    chk("async_rst_overrun", overrun, 1'b0);
    chk("async_rst_irq", irq, 1'b0);
    chk("async_rst_not_empty", rx_not_empty, 1'b0);
    chk("async_rst_full", rx_full, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    rx_busy = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller for the UART receive path. It generates the 16x-oversampling tick (sck_rising_edge) that drives the UART receiver. It collects completed bytes and their frame-error flags into a small receive FIFO, and presents them to the peripheral register interface through a read handshake. Status flags and a level-threshold interrupt are also provided. It sits between the UART receiver and the UART register block.

Parameters:
FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2
DIV_WIDTH, 16, width of baud divider

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  receive enable
clk_div  input  DIV_WIDTH  tick period minus one, in clk cycles
flush  input  1  empty FIFO (single-cycle pulse)
err_clr  input  1  clear sticky overrun/frame_error
irq_threshold  input  $clog2(FIFO_DEPTH+1)  irq asserted when level >= this (0 disables level irq)
sck_rising_edge  output  1  oversampling tick to receiver
rx_busy  input  1  receiver busy
rx_data_valid  input  1  receiver byte-complete pulse
rx_data  input  8  received byte
rx_error  input  1  stop-bit error; valid in same cycle as rx_data_valid
rd_req  input  1  pop request from register block
rd_data  output  8  popped byte
rd_valid  output  1  rd_data valid pulse
level  output  $clog2(FIFO_DEPTH+1)  entries held
rx_not_empty  output  1  level != 0
rx_full  output  1  level == FIFO_DEPTH
overrun  output  1  sticky: byte dropped because FIFO full
frame_error  output  1  sticky: byte received with rx_error=1
irq  output  1  interrupt

Behaviour:
- Reset (async): tick counter 0, sck_rising_edge 0, FIFO empty, level 0, rd_data 0, rd_valid 0, overrun 0, frame_error 0, registered rx_busy copy 0. All outputs low.
- Tick generator:
  - en=0: counter held at 0, sck_rising_edge=0.
  - en=1: when counter >= clk_div, sck_rising_edge=1 for one cycle and counter<=0; otherwise counter+1.
  - clk_div=0 gives a tick every cycle.
  - A clk_div decrease below the current count produces a tick on the next cycle.
  - Phase realign: in the cycle the registered rx_busy is 0 and rx_busy is 1 (rising edge), counter<=0 and no tick is issued that cycle; tick-at-boundary is suppressed.
- sck_rising_edge is registered (driven from flop).
- Push: en=1 and rx_data_valid=1.
  - Not full, or popped in the same cycle: write {rx_data}, level+1 (net 0 if simultaneous pop).
  - Full with no pop: byte dropped, overrun<=1.
  - rx_error=1 with valid: byte stored normally (if space) and frame_error<=1.
  - en=0: pushes ignored, no flags set.
- Pop: rd_req=1 and level!=0.
  - Next cycle: rd_data=oldest byte, rd_valid=1 for one cycle, level-1.
  - rd_req with level==0: no change, rd_valid=0, rd_data holds its last value.
  - Reads are serviced regardless of en.
- Simultaneous push and pop: both occur, level unchanged. At full this is not an overrun.
- Pointers wrap modulo FIFO_DEPTH; level has one extra bit to distinguish full from empty.
- flush: highest priority.
  - Pointers and level cleared next cycle.
  - A same-cycle push is discarded without setting overrun.
  - A same-cycle pop is ignored (rd_valid=0).
  - Sticky flags unaffected.
- err_clr clears overrun and frame_error. A set in the same cycle wins over the clear.
- irq = (irq_threshold!=0 && level>=irq_threshold) | overrun | frame_error. irq is combinational from registers.
- Reset mid-byte: all state cleared immediately; the receiver is reset by the same rst_n.

Test Plan:
- Tick period: en=1, clk_div=3 -> sck_rising_edge every 4 clk; clk_div=0 -> every clk; en=0 -> none, counter 0.
- Realign: clk_div=15, rx_busy rises when counter=9 -> next tick exactly 16 clk after the rise, no tick in the rise cycle.
- FIFO order: push 0xA5,0x3C,0x01 (with no reads), then rd_req x3 -> rd_data A5,3C,01 each with a 1-cycle rd_valid pulse; level 3->0; extra rd_req -> rd_valid=0.
- Overrun: FIFO_DEPTH=4, push 5 bytes 0x10..0x14 -> level 4, rx_full=1, overrun=1, irq=1, 0x14 lost. Push+pop same cycle at full -> level stays 4, no new overrun after err_clr.
- Frame error: push 0x55 with rx_error=1 -> stored, frame_error=1. err_clr and error push in the same cycle -> frame_error stays 1.
- Threshold/flush: irq_threshold=2, push 2 -> irq=1. flush concurrent with a push -> level 0 next cycle, irq=0, overrun unchanged. Assert rst_n low mid-stream -> all outputs 0 asynchronously.
